// File: rtl/ldl_fifo_rd_stream.sv
// Read-side engine for the LDL synchronous FIFO: pops words and presents them as a valid/ready
// stream through a 2-entry buffer. Define LDL_FIFO_RD_AHEAD_EN for a first-word-fall-through source.
module ldl_fifo_rd_stream #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    lvl
);

  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    cnt_pop;
  logic [2:0]    occ;
  logic          pend_q;
  logic          pop;
  logic          land;

  assign m_valid = (cnt_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign cnt_pop = cnt_q - {1'b0, pop};

  // Occupancy seen by the issue rule includes any word still in flight from the FIFO.
  assign occ     = {1'b0, cnt_pop} + {2'b00, pend_q};
  assign fifo_re = rst & ~fifo_empty & (occ <= 3'd1);

`ifdef LDL_FIFO_RD_AHEAD_EN
  // Fall-through source: data is valid alongside the pop, so it lands in the same cycle.
  assign pend_q = 1'b0;
  assign land   = fifo_re;
`else
  assign land   = pend_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= fifo_re;
    end
  end
`endif

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_pop + {1'b0, land};
    if (pop && (cnt_q == 2'd2)) begin
      buf0_d = buf1_q;
    end
    // Landing word goes into the lowest slot left free after this cycle's pop.
    if (land) begin
      if (cnt_pop == 2'd0) begin
        buf0_d = fifo_dout;
      end else begin
        buf1_d = fifo_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign m_data = buf0_q;
  assign lvl    = cnt_q;

endmodule

// File: tb/tb_ldl_fifo_rd_stream.sv
// Directed and random bench for ldl_fifo_rd_stream with a behavioural source FIFO and a
// scoreboard queue; follows LDL_FIFO_RD_AHEAD_EN for the source FIFO read latency.
module tb_ldl_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_re;
  logic [7:0] fifo_dout = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [1:0] lvl;

  logic       we = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] fq[$];
  logic [7:0] sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  logic       s_re, s_valid, s_empty;
  logic [7:0] s_data;
  logic [1:0] s_lvl;
  logic       pend_tb = 1'b0;
  int         re_run = 0, re_max = 0, vr_run = 0, vr_max = 0;
  logic [7:0] d;

  always #5 clk = ~clk;

  ldl_fifo_rd_stream #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_re   (fifo_re),
    .fifo_dout (fifo_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .lvl       (lvl)
  );

  // Behavioural source FIFO: registered empty flag, read data per the AHEAD setting.
  always @(posedge clk) begin
    if (fifo_re && fq.size() != 0) begin
`ifdef LDL_FIFO_RD_AHEAD_EN
      void'(fq.pop_front());
`else
      fifo_dout <= fq.pop_front();
`endif
    end
    if (we) fq.push_back(wdata);
    fifo_empty <= (fq.size() == 0);
`ifdef LDL_FIFO_RD_AHEAD_EN
    if (fq.size() != 0) fifo_dout <= fq[0];
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, run the per-cycle checks.
  task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic rs);
    logic [7:0] e;
    we      = w;
    wdata   = wd;
    m_ready = r;
    rst     = rs;
    if (w) sb.push_back(wd);
    @(negedge clk);
    s_re    = fifo_re;
    s_valid = m_valid;
    s_empty = fifo_empty;
    s_data  = m_data;
    s_lvl   = lvl;
    chk("re_when_empty", 32'(s_re & s_empty), 32'd0);
    chk("lvl_plus_pend", 32'({1'b0, s_lvl} + {2'b00, pend_tb} <= 3'd2), 32'd1);
    if (s_valid && m_ready) begin
      chk("sb_has_word", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_order", 32'(s_data), 32'(e));
      end
      vr_run++;
    end else begin
      vr_run = 0;
    end
    re_run = s_re ? re_run + 1 : 0;
    if (re_run > re_max) re_max = re_run;
    if (vr_run > vr_max) vr_max = vr_run;
    @(posedge clk);
`ifdef LDL_FIFO_RD_AHEAD_EN
    pend_tb = 1'b0;
`else
    pend_tb = s_re;
`endif
    #1;
    we = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held with a word in the source FIFO.
    step(1'b1, 8'hA1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rst_re", 32'(s_re), 32'd0);
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_data", 32'(s_data), 32'd0);
      chk("rst_lvl", 32'(s_lvl), 32'd0);
      chk("rst_src_nonempty", 32'(s_empty), 32'd0);
    end

    // Single word: read issues right after reset release.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("single_re", 32'(s_re), 32'd1);
`ifndef LDL_FIFO_RD_AHEAD_EN
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("single_valid_early", 32'(s_valid), 32'd0);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("single_valid", 32'(s_valid), 32'd1);
    chk("single_data", 32'(s_data), 32'hA1);
    chk("single_lvl", 32'(s_lvl), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("single_lvl_after", 32'(s_lvl), 32'd0);
    chk("single_valid_after", 32'(s_valid), 32'd0);

    // Streaming 0x01..0x10.
    re_max = 0;
    vr_max = 0;
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1, 1'b1);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("stream_re_run", 32'(re_max), 32'd16);
    chk("stream_data_run", 32'(vr_max), 32'd16);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);
    chk("stream_lvl", 32'(s_lvl), 32'd0);

    // Backpressure mid-stream.
    d = 8'h20;
    repeat (6) begin
      step(1'b1, d, 1'b1, 1'b1);
      d++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, d, 1'b0, 1'b1);
      d++;
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_data_held", 32'(s_data), 32'(sb[0]));
      if (i >= 1) begin
        chk("bp_lvl", 32'(s_lvl), 32'd2);
        chk("bp_re", 32'(s_re), 32'd0);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, d, 1'b1, 1'b1);
      d++;
      chk("bp_resume_valid", 32'(s_valid), 32'd1);
    end
    repeat (10) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), 1'b1);
    end
    for (int i = 0; i < 40 && (sb.size() != 0 || s_lvl != 2'd0); i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
    end
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("rand_lvl", 32'(s_lvl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ldl_fifo_rd_stream.md
# ldl_fifo_rd_stream

Read-side engine for the LDL synchronous FIFO. It drains the FIFO's `we`/`re`/`empty` read port and presents the words as a valid/ready stream with full throughput and backpressure. It owns the FIFO read enable, absorbs the FIFO read latency in a 2-entry buffer, and never drops or duplicates a word. It sits between `LDL_sfifo_v1` and any ready/valid consumer.

## Interface
- `DW`, 8, data width; must equal the FIFO `DW`.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_re`  out  1  FIFO read enable (pop).
- `fifo_dout`  in  DW  FIFO read data.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word when `m_valid & m_ready`.
- `m_data`  out  DW  output word.
- `lvl`  out  2  words held in the buffer, 0..2; excludes an in-flight read.

## Operation
- State: `buf0` (output register, drives `m_data`), `buf1` (skid), `cnt` (0..2, = `lvl`), `pend` (a read was issued last cycle and the data has not yet landed).
- `pop = m_valid & m_ready`; `m_valid = (cnt != 0)`.
- Issue rule, default mode: `fifo_re = rst & ~fifo_empty & (cnt + pend - pop <= 1)`. This is a combinational path from `m_ready` to `fifo_re` and is permitted.
- Landing: if `pend`, the word on `fifo_dout` is written into the lowest free slot after this cycle's pop. The target is `buf0` if `buf0` is empty or being popped while `buf1` is empty; otherwise it is `buf1`.
- On pop with `cnt == 2`, `buf1` shifts into `buf0`. A pop and a landing in the same cycle leave `cnt` unchanged.
- `pend` next = `fifo_re`.
- Order is strictly FIFO. `cnt + pend` never exceeds 2. Overflow of the 2-entry buffer is impossible by construction.
- Reset (`rst == 0` at an edge): `cnt = 0`, `pend = 0`, `buf0 = buf1 = 0`. While `rst == 0`, `fifo_re` is forced to 0.
- Reset mid-operation discards the buffered words and any in-flight word. The FIFO must be reset in the same cycle.

## Timing
- Reset values: `m_valid = 0`, `m_data = 0`, `lvl = 0`, `fifo_re = 0`.
- Default mode: `fifo_re` high in cycle T → word on `fifo_dout` in T+1 → captured at the end of T+1 → `m_valid` high in T+2. Read-to-valid latency is 2 cycles.
- Steady state with `m_ready` held at 1 and the FIFO non-empty: `cnt = 1`, `pend = 1`, and one word per cycle in each direction.
- When `m_ready` goes low: at most one more read issues, then `fifo_re` stays 0 with `cnt = 2`, `pend = 0`.
- When `fifo_empty` rises: no read issues that cycle. A pending word still lands.
- `m_data` is stable while `m_valid & ~m_ready`.

## Configuration
- `LDL_FIFO_RD_AHEAD_EN` defined: the source FIFO is built with `AHEAD = 1` (first-word-fall-through).
  - `fifo_dout` is valid whenever `~fifo_empty`, and `pend` is tied to 0.
  - `fifo_re = rst & ~fifo_empty & (cnt - pop <= 1)`. The word is captured at the end of the same cycle, so `m_valid` rises in T+1. Latency is 1.
- `LDL_FIFO_RD_AHEAD_EN` undefined: the source FIFO is built with `AHEAD = 0`, and the default-mode rules above apply.

## Test plan
- Reset, default mode: hold `rst = 0` for 3 cycles with `fifo_empty = 0`. Required: `fifo_re = 0`, `m_valid = 0`, `m_data = 0`, `lvl = 0` throughout.
- Single word, default mode: FIFO holds 0xA1 and `m_ready = 1`. Required:
  - `fifo_re` pulses in cycle T.
  - `m_valid` is high in T+2 with `m_data = 0xA1`.
  - After the pop, `lvl = 0`.
- Streaming: FIFO preloaded with 0x01..0x10 and `m_ready = 1`. Required:
  - `fifo_re` is high for 16 consecutive cycles.
  - `m_data` carries 0x01..0x10 on 16 consecutive cycles.
  - `fifo_re` never fires while `fifo_empty = 1`.
- Backpressure: during streaming, drop `m_ready` for 5 cycles. Required:
  - `lvl` settles at 2 and `fifo_re` stays at 0.
  - `m_data` is held constant.
  - After `m_ready` returns, the sequence resumes with no gap, loss or repeat.
- Random traffic: random `we`/`m_ready` at 50% for 2000 cycles, checked against a scoreboard queue. Required: exact in-order match, and `lvl + pend <= 2` always.
- AHEAD build: with `LDL_FIFO_RD_AHEAD_EN` defined, repeat the single-word and streaming cases. Required: `m_valid` rises 1 cycle after `fifo_re`, and the output sequence is identical to the default build.
